// File: rtl/gcd_seq_ctrl_if.sv
// Operand/result handshake bundle for the sequential GCD engine.
// Signal suffixes are from the engine's point of view.
interface gcd_seq_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 8
);
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] result_o;
    logic             valid_o;
    logic             ready_i;
    logic [CNTW-1:0]  iters_o;
    logic             busy_o;

    modport slave (
        input  a_i, b_i, valid_i, ready_i,
        output ready_o, result_o, valid_o, iters_o, busy_o
    );

    modport master (
        output a_i, b_i, valid_i, ready_i,
        input  ready_o, result_o, valid_o, iters_o, busy_o
    );
endinterface

// File: rtl/gcd_seq_ctrl.sv
// Sequential binary (Stein) GCD engine with one shared trailing-zero counter
// that the FSM time-shares for power-of-two extraction and operand normalising.
module tzn32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]       data_i,
    output logic [$clog2(WIDTH):0] numz_o
);
    localparam int NW = $clog2(WIDTH) + 1;

    // Scanning from the MSB down leaves the lowest set bit's index; all-zero gives WIDTH.
    always_comb begin
        numz_o = NW'(WIDTH);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (data_i[i]) numz_o = NW'(i);
        end
    end
endmodule

module gcd_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 8
) (
    input  logic           clock_i,
    input  logic           reset_ni,
    gcd_seq_ctrl_if.slave  bus_io
);
    localparam int NW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        COMMON,
        NORM_A,
        NORM_B,
        SUB,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [NW-1:0]    k_q, k_d;
    logic [CNTW-1:0]  iters_q, iters_d;
    logic [WIDTH-1:0] tzIn;
    logic [NW-1:0]    tzCount;

    always_comb begin
        tzIn = '0;
        unique case (state_q)
            COMMON:  tzIn = a_q | b_q;
            NORM_A:  tzIn = a_q;
            NORM_B:  tzIn = b_q;
            default: tzIn = '0;
        endcase
    end

    tzn32 #(.WIDTH(WIDTH)) u_tzn (
        .data_i (tzIn),
        .numz_o (tzCount)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        k_d      = k_q;
        iters_d  = iters_q;
        unique case (state_q)
            IDLE: begin
                if (bus_io.valid_i) begin
                    a_d     = bus_io.a_i;
                    b_d     = bus_io.b_i;
                    iters_d = '0;
                    state_d = COMMON;
                end
            end
            COMMON: begin
                if (a_q == '0 || b_q == '0) begin
                    result_d = a_q | b_q;
                    state_d  = DONE;
                end else begin
                    k_d     = tzCount;
                    state_d = NORM_A;
                end
            end
            NORM_A: begin
                a_d     = a_q >> tzCount;
                state_d = NORM_B;
            end
            NORM_B: begin
                b_d     = b_q >> tzCount;
                state_d = SUB;
            end
            SUB: begin
                if (iters_q != '1) iters_d = iters_q + CNTW'(1);
                // Both odd here, so any difference is even and nonzero, ready for NORM_B.
                if (a_q == b_q) begin
                    result_d = a_q << k_q;
                    state_d  = DONE;
                end else if (a_q > b_q) begin
                    a_d     = b_q;
                    b_d     = a_q - b_q;
                    state_d = NORM_B;
                end else begin
                    b_d     = b_q - a_q;
                    state_d = NORM_B;
                end
            end
            DONE: begin
                if (bus_io.ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            k_q      <= '0;
            iters_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            k_q      <= k_d;
            iters_q  <= iters_d;
        end
    end

    assign bus_io.ready_o  = (state_q == IDLE);
    assign bus_io.valid_o  = (state_q == DONE);
    assign bus_io.busy_o   = (state_q != IDLE);
    assign bus_io.result_o = result_q;
    assign bus_io.iters_o  = iters_q;
endmodule

// File: tb/tb_gcd_seq_ctrl.sv
// Self-checking bench for gcd_seq_ctrl: directed vector table, backpressure,
// mid-operation reset and a back-to-back random regression against a Euclid model.
module tb_gcd_seq_ctrl;
    localparam int WIDTH       = 32;
    localparam int CNTW        = 8;
    localparam int NUM_VECTORS = 7;
    localparam int NUM_RANDOM  = 1000;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expResult;
        int          expIters;
        int          expLatency;
    } vector_t;

    logic        clk;
    logic        rst_n;
    int          passCount = 0;
    int          checkCount = 0;
    logic [31:0] expQ[$];
    vector_t     vectors[NUM_VECTORS];

    gcd_seq_ctrl_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

    gcd_seq_ctrl #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clock_i  (clk),
        .reset_ni (rst_n),
        .bus_io   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    function automatic logic [31:0] refGcd(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [31:0] randOperand();
        int          w;
        logic [31:0] v;
        w = $urandom_range(1, 32);
        v = $urandom;
        if (w < 32) v = v & ((32'd1 << w) - 32'd1);
        return v;
    endfunction

    // Called on a falling edge; returns on the falling edge right after the accept edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expResult);
        int waitCycles = 0;
        @(negedge clk);
        bus.a_i     = a;
        bus.b_i     = b;
        bus.valid_i = 1'b1;
        while (!bus.ready_o && waitCycles < 300) begin
            @(negedge clk);
            waitCycles++;
        end
        check("ready_before_accept", 64'(bus.ready_o), 64'(1));
        @(posedge clk);
        expQ.push_back(expResult);
        @(negedge clk);
        bus.valid_i = 1'b0;
    endtask

    // Latency counts the accept edge as edge 1.
    task automatic waitValid(output int lat);
        lat = 1;
        while (!bus.valid_o && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic checkOutput(input int expIters);
        logic [31:0] expResult = '0;
        check("scoreboard_nonempty", 64'(expQ.size() > 0), 64'(1));
        if (expQ.size() > 0) expResult = expQ.pop_front();
        check("valid_o_high", 64'(bus.valid_o), 64'(1));
        check("result_o", 64'(bus.result_o), 64'(expResult));
        check("iters_o", 64'(bus.iters_o), 64'(expIters));
        check("ready_o_low_in_done", 64'(bus.ready_o), 64'(0));
        check("busy_o_in_done", 64'(bus.busy_o), 64'(1));
    endtask

    task automatic releaseResult(input int expIters);
        bus.ready_i = 1'b1;
        @(negedge clk);
        bus.ready_i = 1'b0;
        check("valid_o_drop", 64'(bus.valid_o), 64'(0));
        check("ready_o_back", 64'(bus.ready_o), 64'(1));
        check("busy_o_idle", 64'(bus.busy_o), 64'(0));
        check("iters_o_hold", 64'(bus.iters_o), 64'(expIters));
    endtask

    initial begin
        int lat;
        int sent = 0;
        int received = 0;
        bit driverDone = 0;

        vectors[0] = '{32'd48,        32'd18,        32'd6,         2,  7};
        vectors[1] = '{32'd0,         32'd0,         32'd0,         0,  2};
        vectors[2] = '{32'd0,         32'd25,        32'd25,        0,  2};
        vectors[3] = '{32'd25,        32'd0,         32'd25,        0,  2};
        vectors[4] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1,  5};
        vectors[5] = '{32'd1,         32'hFFFF_FFFF, 32'd1,         32, 67};
        vectors[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         32, 67};

        rst_n       = 1'b0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        #12;
        check("reset_ready_o", 64'(bus.ready_o), 64'(1));
        check("reset_valid_o", 64'(bus.valid_o), 64'(0));
        check("reset_busy_o", 64'(bus.busy_o), 64'(0));
        check("reset_result_o", 64'(bus.result_o), 64'(0));
        check("reset_iters_o", 64'(bus.iters_o), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed vectors");
        for (int i = 0; i < NUM_VECTORS; i++) begin
            applyStimulus(vectors[i].a, vectors[i].b, vectors[i].expResult);
            check("ready_o_after_accept", 64'(bus.ready_o), 64'(0));
            check("busy_o_after_accept", 64'(bus.busy_o), 64'(1));
            waitValid(lat);
            check("latency", 64'(lat), 64'(vectors[i].expLatency));
            checkOutput(vectors[i].expIters);
            releaseResult(vectors[i].expIters);
        end

        $display("[TB] backpressure");
        applyStimulus(32'd48, 32'd18, 32'd6);
        waitValid(lat);
        for (int c = 0; c < 10; c++) begin
            bus.valid_i = c[0];
            bus.a_i     = $urandom;
            bus.b_i     = $urandom;
            @(negedge clk);
            check("bp_valid_o", 64'(bus.valid_o), 64'(1));
            check("bp_result_o", 64'(bus.result_o), 64'(6));
            check("bp_ready_o", 64'(bus.ready_o), 64'(0));
        end
        bus.valid_i = 1'b0;
        checkOutput(2);
        releaseResult(2);

        $display("[TB] reset during SUB");
        applyStimulus(32'd48, 32'd18, 32'd6);
        repeat (3) @(negedge clk);
        check("midop_busy_o", 64'(bus.busy_o), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_ready_o", 64'(bus.ready_o), 64'(1));
        check("async_reset_valid_o", 64'(bus.valid_o), 64'(0));
        check("async_reset_busy_o", 64'(bus.busy_o), 64'(0));
        check("async_reset_result_o", 64'(bus.result_o), 64'(0));
        check("async_reset_iters_o", 64'(bus.iters_o), 64'(0));
        expQ.delete();
        repeat (2) begin
            @(negedge clk);
            check("reset_hold_valid_o", 64'(bus.valid_o), 64'(0));
        end
        rst_n = 1'b1;
        applyStimulus(32'd35, 32'd14, 32'd7);
        waitValid(lat);
        check("post_reset_latency", 64'(lat), 64'(7));
        checkOutput(2);
        releaseResult(2);

        $display("[TB] random back-to-back regression");
        bus.ready_i = 1'b1;
        fork
            begin
                for (int i = 0; i < NUM_RANDOM; i++) begin
                    logic [31:0] a;
                    logic [31:0] b;
                    int          waitCycles;
                    a = randOperand();
                    b = randOperand();
                    case ($urandom_range(0, 5))
                        3: a = 32'd1 << $urandom_range(0, 31);
                        4: b = a;
                        5: begin
                            a = 32'd1 << $urandom_range(0, 31);
                            b = 32'd1 << $urandom_range(0, 31);
                        end
                        default: ;
                    endcase
                    bus.a_i     = a;
                    bus.b_i     = b;
                    bus.valid_i = 1'b1;
                    waitCycles  = 0;
                    while (!bus.ready_o && waitCycles < 400) begin
                        @(negedge clk);
                        waitCycles++;
                    end
                    if (!bus.ready_o) break;
                    expQ.push_back(refGcd(a, b));
                    sent++;
                    @(posedge clk);
                    @(negedge clk);
                end
                bus.valid_i = 1'b0;
                driverDone  = 1;
            end
            begin
                int cyc = 0;
                while ((!driverDone || received < sent) && cyc < 80000) begin
                    @(negedge clk);
                    cyc++;
                    if (bus.valid_o) begin
                        logic [31:0] expResult = '0;
                        if (expQ.size() > 0) expResult = expQ.pop_front();
                        check("random_result", 64'(bus.result_o), 64'(expResult));
                        received++;
                    end
                end
            end
        join
        bus.ready_i = 1'b0;
        check("random_sent", 64'(sent), 64'(NUM_RANDOM));
        check("random_received", 64'(received), 64'(NUM_RANDOM));
        check("random_leftover", 64'(expQ.size()), 64'(0));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
